// File: rtl/pipe_muxn_pkg.sv
// Shared constants and helpers for the pipelined N-way channel mux.
package pipe_muxn_pkg;

  localparam int DEF_WIDTH  = 64;
  localparam int DEF_NUM_IN = 8;

  // Select width, never narrower than one bit.
  function automatic int sel_w(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/pipe_muxn_muxn.sv
// Combinational N-way mux over a flattened channel bus.
// An out-of-range select yields all zeros.
module muxn
  import pipe_muxn_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int NUM_IN = DEF_NUM_IN,
  localparam int SEL_W = sel_w(NUM_IN)
) (
  input  logic [NUM_IN*WIDTH-1:0] in,
  input  logic [SEL_W-1:0]        sel,
  output logic [WIDTH-1:0]        out
);

  always_comb begin
    out = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (sel == SEL_W'(k)) out = in[k*WIDTH +: WIDTH];
    end
  end

endmodule

// File: rtl/pipe_muxn.sv
// Registered N-way channel mux with valid/ready handshake.
// Define PIPE_MUXN_SCAN_EN to build in the round-robin scan counter.
module pipe_muxn
  import pipe_muxn_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int NUM_IN = DEF_NUM_IN,
  localparam int SEL_W = sel_w(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_IN*WIDTH-1:0] in,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    scan_mode,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    out_valid,
  input  logic                    out_ready
);

  logic             accept;
  logic [SEL_W-1:0] eff_sel;
  logic [WIDTH-1:0] mux_out;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

`ifdef PIPE_MUXN_SCAN_EN
  logic [SEL_W-1:0] scan_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      scan_cnt <= '0;
    end else if (accept && scan_mode) begin
      if (scan_cnt == SEL_W'(NUM_IN-1)) scan_cnt <= '0;
      else scan_cnt <= scan_cnt + 1'b1;
    end
  end

  assign eff_sel = scan_mode ? scan_cnt : sel;
`else
  logic unused_scan_mode;
  assign unused_scan_mode = scan_mode;
  assign eff_sel = sel;
`endif

  muxn #(
    .WIDTH (WIDTH),
    .NUM_IN(NUM_IN)
  ) u_muxn (
    .in (in),
    .sel(eff_sel),
    .out(mux_out)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      out       <= '0;
      out_sel   <= '0;
      out_valid <= 1'b0;
    end else if (accept) begin
      out       <= mux_out;
      out_sel   <= eff_sel;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/pipe_muxn.md
PIPE_MUXN -- requirements
Module: pipe_muxn

Interface
REQ-001 SHALL have parameter WIDTH, default 64, bit width of each data channel.
REQ-002 SHALL have parameter NUM_IN, default 8, number of input channels (2..64).
REQ-003 SHALL derive localparam SEL_W = max(1, clog2(NUM_IN)).
REQ-004 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-005 Port: reset  input  1  synchronous, active-high reset.
REQ-006 Port: in  input  NUM_IN*WIDTH  flattened channels; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-007 Port: sel  input  SEL_W  channel select, used when scan mode is inactive.
REQ-008 Port: scan_mode  input  1  1 = internal scan counter selects the channel.
REQ-009 Port: in_valid  input  1  upstream presents a transfer.
REQ-010 Port: in_ready  output  1  block accepts a transfer this cycle.
REQ-011 Port: out  output  WIDTH  registered selected data.
REQ-012 Port: out_sel  output  SEL_W  channel index that produced out.
REQ-013 Port: out_valid  output  1  out/out_sel hold a valid result.
REQ-014 Port: out_ready  input  1  downstream consumes the result this cycle.

Function
REQ-015 in_ready SHALL be combinational: !out_valid || out_ready.
REQ-016 Accept occurs when in_valid && in_ready; on accept, out <= channel[eff_sel], out_sel <= eff_sel, out_valid <= 1, on the next edge (latency 1).
REQ-017 eff_sel SHALL be scan_cnt when scan is active, else sel.
REQ-018 If eff_sel >= NUM_IN (non-power-of-2 NUM_IN), out SHALL load all zeros; out_sel SHALL load eff_sel unchanged.
REQ-019 Consume without accept (out_valid && out_ready && !in_valid) SHALL clear out_valid; out/out_sel SHALL hold.
REQ-020 Simultaneous consume and accept SHALL load new data with out_valid remaining 1 (full throughput, one result per cycle).
REQ-021 While out_valid && !out_ready, out, out_sel and out_valid SHALL hold stable.
REQ-022 in and sel are sampled only at accept; changes at other times SHALL have no effect.

Reset
REQ-023 On reset = 1 at a clock edge: out = 0, out_sel = 0, out_valid = 0, scan_cnt = 0.
REQ-024 Reset SHALL override a simultaneous accept; in-flight result is discarded.
REQ-025 in_ready SHALL read 1 in the cycle following reset.

Configuration
REQ-026 Macro PIPE_MUXN_SCAN_EN SHALL compile in the scan counter.
REQ-027 With PIPE_MUXN_SCAN_EN: scan active when scan_mode = 1; scan_cnt SHALL increment by 1 on each accept while scan is active, wrapping NUM_IN-1 -> 0; scan_cnt SHALL hold when scan_mode = 0 or no accept.
REQ-028 Without PIPE_MUXN_SCAN_EN: scan_mode port SHALL remain present but be ignored; no scan_cnt register; eff_sel = sel always.

Structure
REQ-029 Package pipe_muxn_pkg SHALL hold default WIDTH/NUM_IN constants and a sel_w(n) width function.
REQ-030 Combinational selection SHALL be a sub-module muxn (parametrised WIDTH, NUM_IN; zero output for out-of-range select); pipe_muxn holds handshake and registers only.

Verification
REQ-031 Reset then NUM_IN=8, WIDTH=64, channel k = 0x1000+k, sel=5, in_valid=1, out_ready=1 -> next cycle out=0x1005, out_sel=5, out_valid=1.
REQ-032 Backpressure: out_ready=0 after one accept, sel changes to 2 -> in_ready=0, out stays 0x1005 until out_ready=1; next accept yields 0x1002.
REQ-033 Streaming: in_valid=out_ready=1 for 8 cycles, sel=0..7 -> out = 0x1000..0x1007 on consecutive cycles, no bubbles.
REQ-034 Scan (PIPE_MUXN_SCAN_EN, scan_mode=1): 10 accepts -> out_sel = 0,1,...,7,0,1 (wrap); without macro same stimulus follows sel.
REQ-035 NUM_IN=5, sel=6 -> out=0, out_sel=6, out_valid=1.
REQ-036 Reset asserted in the same cycle as an accept -> out_valid=0, out=0 next cycle; in_ready=1.
